// File: rtl/cdb_complete_queue_pkg.sv
// Shared system definitions for the completion side of the R10K core:
// broadcast width, physical tag width and the completion-queue entry format.
package cdb_complete_queue_pkg;

    localparam int N_WAY    = 2;
    localparam int CDB_BITS = 6;

    // Tag only for now; rob_idx will be added here when the ROB needs it.
    typedef struct packed {
        logic [CDB_BITS-1:0] tag;
    } cq_entry_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cdb_complete_queue_age_select.sv
// Combinational age merge: queue head window first, then this cycle's accepted
// FU ports in ascending index order, split into broadcast slots and a push list.
module cq_age_select
    import cdb_complete_queue_pkg::*;
#(
    parameter int N_FU  = 4,
    parameter int CNT_W = 4
) (
    input  logic [N_WAY-1:0][CDB_BITS-1:0] q_tag,
    input  logic [CNT_W-1:0]               q_count,
    input  logic                           accept_en,
    input  logic [N_FU-1:0]                fu_valid,
    input  logic [N_FU-1:0][CDB_BITS-1:0]  fu_tag,
    output logic [N_WAY-1:0][CDB_BITS-1:0] slot_tag,
    output logic [$clog2(N_WAY):0]         slot_num,
    output logic [CNT_W-1:0]               pop_count,
    output logic [$clog2(N_FU):0]          push_count,
    output logic [N_FU-1:0][CDB_BITS-1:0]  push_tag
);

    localparam int SW = $clog2(N_WAY) + 1;
    localparam int AW = $clog2(N_FU) + 1;

    logic [N_FU-1:0][CDB_BITS-1:0] acc_tag;
    int acc_n;
    int q_n;
    int in_n;

    // Compact accepted ports; a valid port carrying the null tag is not a completion.
    always_comb begin
        acc_tag = '0;
        acc_n   = 0;
        for (int i = 0; i < N_FU; i++) begin
            if (accept_en && fu_valid[i] && (fu_tag[i] != '0)) begin
                for (int j = 0; j < N_FU; j++) begin
                    if (j == acc_n) acc_tag[j] = fu_tag[i];
                end
                acc_n = acc_n + 1;
            end
        end
    end

    always_comb begin
        q_n      = min_int(int'(q_count), N_WAY);
        in_n     = min_int(acc_n, N_WAY - q_n);
        slot_tag = '0;
        push_tag = '0;
        for (int k = 0; k < N_WAY; k++) begin
            if (k < q_n) begin
                slot_tag[k] = q_tag[k];
            end else begin
                for (int j = 0; j < N_FU; j++) begin
                    if ((j == k - q_n) && (j < acc_n)) slot_tag[k] = acc_tag[j];
                end
            end
        end
        // Incoming tags that did not fit in the broadcast go to the queue tail.
        for (int p = 0; p < N_FU; p++) begin
            for (int j = 0; j < N_FU; j++) begin
                if ((j == p + in_n) && (j < acc_n)) push_tag[p] = acc_tag[j];
            end
        end
        slot_num   = SW'(q_n + in_n);
        pop_count  = CNT_W'(q_n);
        push_count = AW'(acc_n - in_n);
    end

endmodule

// File: rtl/cdb_complete_queue.sv
// In-order completion queue feeding the CDB: buffers finished dest tags from the
// FUs and broadcasts up to N_WAY of them per cycle, oldest first.
module cdb_complete_queue
    import cdb_complete_queue_pkg::*;
#(
    parameter int N_FU     = 4,
    parameter int CQ_DEPTH = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           squash,
    input  logic [N_FU-1:0]                fu_valid,
    input  logic [N_FU-1:0][CDB_BITS-1:0]  fu_tag,
    output logic [N_FU-1:0]                fu_ready,
    output logic [N_WAY-1:0][CDB_BITS-1:0] complete_dest_tag,
    output logic [$clog2(N_WAY):0]         complete_num,
    output logic [$clog2(CQ_DEPTH):0]      cq_count
);

    localparam int PW = $clog2(CQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(N_FU) + 1;

    cq_entry_t mem [CQ_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic [CW-1:0]                  free_cnt;
    logic                           ready;
    logic                           accept_en;
    logic [N_WAY-1:0][CDB_BITS-1:0] q_tag;
    logic [N_WAY-1:0][CDB_BITS-1:0] slot_tag;
    logic [$clog2(N_WAY):0]         slot_num;
    logic [CW-1:0]                  pop_count;
    logic [AW-1:0]                  push_count;
    logic [N_FU-1:0][CDB_BITS-1:0]  push_tag;

    // Ready depends only on the registered count, so a full burst on every port always fits.
    assign free_cnt  = CW'(CQ_DEPTH) - cq_count;
    assign ready     = (free_cnt >= CW'(N_FU));
    assign fu_ready  = {N_FU{ready}};
    assign accept_en = ready && !squash;

    always_comb begin
        for (int k = 0; k < N_WAY; k++) begin
            q_tag[k] = mem[head + PW'(k)].tag;
        end
    end

    cq_age_select #(
        .N_FU  (N_FU),
        .CNT_W (CW)
    ) u_age_select (
        .q_tag      (q_tag),
        .q_count    (cq_count),
        .accept_en  (accept_en),
        .fu_valid   (fu_valid),
        .fu_tag     (fu_tag),
        .slot_tag   (slot_tag),
        .slot_num   (slot_num),
        .pop_count  (pop_count),
        .push_count (push_count),
        .push_tag   (push_tag)
    );

    // Broadcast register stage: outputs, pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            complete_dest_tag <= '0;
            complete_num      <= '0;
            head              <= '0;
            tail              <= '0;
            cq_count          <= '0;
        end else if (squash) begin
            complete_dest_tag <= '0;
            complete_num      <= '0;
            head              <= tail;
            cq_count          <= '0;
        end else begin
            complete_dest_tag <= slot_tag;
            complete_num      <= slot_num;
            head              <= head + PW'(pop_count);
            tail              <= tail + PW'(push_count);
            cq_count          <= cq_count + CW'(push_count) - pop_count;
        end
    end

    // Storage carries no reset; only entries between head and tail are ever read.
    always_ff @(posedge clock) begin
        for (int p = 0; p < N_FU; p++) begin
            if (int'(push_count) > p) mem[tail + PW'(p)].tag <= push_tag[p];
        end
    end

    function automatic logic has_dup(input logic [N_WAY-1:0][CDB_BITS-1:0] t);
        logic dup;
        dup = 1'b0;
        for (int a = 0; a < N_WAY; a++) begin
            for (int b = a + 1; b < N_WAY; b++) begin
                if ((t[a] != '0) && (t[a] == t[b])) dup = 1'b1;
            end
        end
        return dup;
    endfunction

    a_no_dup_tag: assert property (@(posedge clock) disable iff (!reset)
        !has_dup(complete_dest_tag))
        else $error("duplicate tag on complete_dest_tag");

    a_count_bound: assert property (@(posedge clock) disable iff (!reset)
        cq_count <= CW'(CQ_DEPTH))
        else $error("cq_count above depth");

endmodule
